// File: rtl/rom_bridge_pkg.sv
// Shared widths, constants and payload types for the instruction-fetch bridge.
package rom_bridge_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD  = '0;
  localparam logic              RST_ENABLE = 1'b0;

  // One-entry instruction buffer
  typedef struct packed {
    logic                   valid;
    logic [INST_ADDR_W-1:0] addr;
    logic [INST_W-1:0]      data;
  } buf_entry_t;

endpackage

// File: rtl/rom_bridge_if.sv
// Core fetch port plus external instruction-memory port of the fetch bridge.
interface rom_bridge_if;
  import rom_bridge_pkg::*;

  logic                   rom_ce_i;
  logic [INST_ADDR_W-1:0] rom_addr_i;
  logic [INST_W-1:0]      rom_data_o;
  logic                   stall_req_o;
  logic                   flush_i;
  logic                   mem_req_o;
  logic [INST_ADDR_W-1:0] mem_addr_o;
  logic                   mem_ack_i;
  logic [INST_W-1:0]      mem_rdata_i;
  logic                   bus_err_o;

  // Environment view: core and memory
  modport master (
    output rom_ce_i, rom_addr_i, flush_i, mem_ack_i, mem_rdata_i,
    input  rom_data_o, stall_req_o, mem_req_o, mem_addr_o, bus_err_o
  );

  // Bridge view
  modport slave (
    input  rom_ce_i, rom_addr_i, flush_i, mem_ack_i, mem_rdata_i,
    output rom_data_o, stall_req_o, mem_req_o, mem_addr_o, bus_err_o
  );

endinterface

// File: rtl/rom_bridge_wdt.sv
// Fetch watchdog: counts busy cycles without an acknowledge.
module rom_bridge_wdt
  import rom_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Clear on a new request, advance on each unacknowledged busy cycle
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th unacknowledged busy cycle
  assign expired_c = en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rom_bridge.sv
// Instruction-fetch bridge: one-entry buffer between core rom_* port and memory.
// Optional fetch timeout enabled by defining ROM_BRIDGE_TIMEOUT_EN.
module rom_bridge
  import rom_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  rom_bridge_if.slave  bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t                 state;
  buf_entry_t             buffer;
  logic [INST_ADDR_W-1:0] req_addr;
  logic                   mem_req;
  logic                   bus_err;
  logic                   hit;
  logic                   start;
  logic                   timeout;

  // Buffer lookup and miss detection
  assign hit   = bus.rom_ce_i && buffer.valid && (buffer.addr == bus.rom_addr_i);
  assign start = (state == ST_IDLE) && bus.rom_ce_i && !hit;

  // Core-facing outputs are combinational and quiet while in reset
  assign bus.rom_data_o  = ((rst != RST_ENABLE) && hit) ? buffer.data : ZERO_WORD;
  assign bus.stall_req_o = (rst != RST_ENABLE) && bus.rom_ce_i && !hit;

  assign bus.mem_req_o  = mem_req;
  assign bus.mem_addr_o = req_addr;
  assign bus.bus_err_o  = bus_err;

`ifdef ROM_BRIDGE_TIMEOUT_EN
  // Abort a fetch that waits too long for the memory
  rom_bridge_wdt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .en        ((state == ST_BUSY) && !bus.mem_ack_i),
    .expired_c (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Fetch FSM, memory request and buffer fill
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state    <= ST_IDLE;
      mem_req  <= 1'b0;
      req_addr <= '0;
      bus_err  <= 1'b0;
      buffer   <= '0;
    end else begin
      bus_err <= 1'b0;
      if (bus.flush_i) begin
        buffer.valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            req_addr <= bus.rom_addr_i;
            mem_req  <= 1'b1;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.mem_ack_i || timeout) begin
            mem_req <= 1'b0;
            state   <= ST_IDLE;
            bus_err <= timeout;
            // A coincident flush discards the returning word
            if (!bus.flush_i) begin
              buffer.valid <= 1'b1;
              buffer.addr  <= req_addr;
              buffer.data  <= bus.mem_ack_i ? bus.mem_rdata_i : ZERO_WORD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_bridge.sv
// Directed bench for rom_bridge with an expected-fill scoreboard.
module tb_rom_bridge;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  rom_bridge_if bus_if ();

  rom_bridge #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Core sees a hit: stall low and the oldest expected fill on rom_data_o
  task automatic expect_hit(input string tag);
    exp_t e;
    check({tag, "_stall"}, 32'(bus_if.stall_req_o), 32'd0);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, bus_if.rom_data_o, e.data);
    end
  endtask

  // Miss at addr a, memory acks after w wait cycles with d, then hit
  task automatic fetch(input string tag, input logic [31:0] a, input int w, input logic [31:0] d);
    @(negedge clk);
    bus_if.rom_ce_i = 1'b1;
    bus_if.rom_addr_i = a;
    #1;
    check({tag, "_miss_stall"}, 32'(bus_if.stall_req_o), 32'd1);
    check({tag, "_miss_req"}, 32'(bus_if.mem_req_o), 32'd0);
    for (int c = 0; c <= w; c++) begin
      @(negedge clk);
      if (c == w) begin
        bus_if.mem_ack_i = 1'b1;
        bus_if.mem_rdata_i = d;
        sb.push_back('{a, d});
      end
      #1;
      check({tag, "_busy_req"}, 32'(bus_if.mem_req_o), 32'd1);
      check({tag, "_busy_addr"}, bus_if.mem_addr_o, a);
      check({tag, "_busy_stall"}, 32'(bus_if.stall_req_o), 32'd1);
      check({tag, "_busy_err"}, 32'(bus_if.bus_err_o), 32'd0);
    end
    @(negedge clk);
    bus_if.mem_ack_i = 1'b0;
    bus_if.mem_rdata_i = '0;
    #1;
    expect_hit({tag, "_hit"});
    check({tag, "_req_drop"}, 32'(bus_if.mem_req_o), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus_if.rom_ce_i = 1'b1;
    bus_if.rom_addr_i = '0;
    bus_if.flush_i = 1'b0;
    bus_if.mem_ack_i = 1'b0;
    bus_if.mem_rdata_i = '0;

    // Reset state with a fetch requested
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(bus_if.mem_req_o), 32'd0);
    check("rst_addr", bus_if.mem_addr_o, 32'd0);
    check("rst_err", 32'(bus_if.bus_err_o), 32'd0);
    check("rst_stall", 32'(bus_if.stall_req_o), 32'd0);
    check("rst_data", bus_if.rom_data_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_if.rom_ce_i = 1'b0;

    // First fetch: three wait cycles
    fetch("t1", 32'h0, 3, 32'h3401_1100);

    // Same address held, plus an acknowledge while idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.mem_ack_i = (i == 1);
      bus_if.mem_rdata_i = (i == 1) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      check("t2_stall", 32'(bus_if.stall_req_o), 32'd0);
      check("t2_req", 32'(bus_if.mem_req_o), 32'd0);
      check("t2_data", bus_if.rom_data_o, 32'h3401_1100);
    end
    bus_if.mem_ack_i = 1'b0;
    bus_if.mem_rdata_i = '0;

    // Address change mid-BUSY keeps the old fill
    @(negedge clk); bus_if.rom_addr_i = 32'h4; #1;
    check("t3_miss", 32'(bus_if.stall_req_o), 32'd1);
    @(negedge clk); bus_if.rom_addr_i = 32'h8; #1;
    check("t3_req", 32'(bus_if.mem_req_o), 32'd1);
    check("t3_addr4", bus_if.mem_addr_o, 32'h4);
    @(negedge clk);
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = 32'h1111_1111;
    sb.push_back('{32'h4, 32'h1111_1111});
    #1;
    check("t3_addr_held", bus_if.mem_addr_o, 32'h4);
    @(negedge clk); bus_if.mem_ack_i = 1'b0; #1;
    check("t3_new_miss", 32'(bus_if.stall_req_o), 32'd1);
    check("t3_req_idle", 32'(bus_if.mem_req_o), 32'd0);
    @(negedge clk); bus_if.rom_addr_i = 32'h4; #1;
    check("t3_req8", 32'(bus_if.mem_req_o), 32'd1);
    check("t3_addr8", bus_if.mem_addr_o, 32'h8);
    expect_hit("t3_old_fill");
    @(negedge clk);
    bus_if.rom_addr_i = 32'h8; bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = 32'h2222_2222;
    sb.push_back('{32'h8, 32'h2222_2222});
    #1;
    check("t3_stall8", 32'(bus_if.stall_req_o), 32'd1);
    @(negedge clk); bus_if.mem_ack_i = 1'b0; #1;
    expect_hit("t3_new_fill");

    // Flush coincident with acknowledge discards the word
    @(negedge clk); bus_if.rom_addr_i = 32'hC; #1;
    check("t4_miss", 32'(bus_if.stall_req_o), 32'd1);
    @(negedge clk); #1;
    check("t4_req", 32'(bus_if.mem_req_o), 32'd1);
    @(negedge clk);
    bus_if.mem_ack_i = 1'b1; bus_if.flush_i = 1'b1; bus_if.mem_rdata_i = 32'h3333_3333;
    #1;
    @(negedge clk); bus_if.mem_ack_i = 1'b0; bus_if.flush_i = 1'b0; #1;
    check("t4_flush_wins", 32'(bus_if.stall_req_o), 32'd1);
    check("t4_data_zero", bus_if.rom_data_o, 32'd0);
    @(negedge clk); #1;
    check("t4_rereq", 32'(bus_if.mem_req_o), 32'd1);
    check("t4_rereq_addr", bus_if.mem_addr_o, 32'hC);
    @(negedge clk);
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = 32'h4444_4444;
    sb.push_back('{32'hC, 32'h4444_4444});
    #1;
    @(negedge clk); bus_if.mem_ack_i = 1'b0; #1;
    expect_hit("t4_refill");
    // Plain flush: hit persists this cycle, gone the next
    @(negedge clk); bus_if.flush_i = 1'b1; #1;
    check("t4_flush_cycle", 32'(bus_if.stall_req_o), 32'd0);
    @(negedge clk); bus_if.flush_i = 1'b0; #1;
    check("t4_after_flush", 32'(bus_if.stall_req_o), 32'd1);
    @(negedge clk); #1;
    check("t4_req2", 32'(bus_if.mem_req_o), 32'd1);
    @(negedge clk);
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = 32'h5555_5555;
    sb.push_back('{32'hC, 32'h5555_5555});
    #1;
    @(negedge clk); bus_if.mem_ack_i = 1'b0; #1;
    expect_hit("t4_refill2");

    // Fetch disabled: zero word, no stall, no request
    @(negedge clk); bus_if.rom_ce_i = 1'b0; bus_if.rom_addr_i = 32'h100; #1;
    check("ce0_data", bus_if.rom_data_o, 32'd0);
    check("ce0_stall", 32'(bus_if.stall_req_o), 32'd0);
    @(negedge clk); #1;
    check("ce0_req", 32'(bus_if.mem_req_o), 32'd0);

    // Sequential PCs each miss
    for (int i = 0; i < 3; i++) begin
      fetch("t5", 32'h10 + 32'(4 * i), i, $urandom);
    end

    // Reset in the middle of a fetch
    @(negedge clk); bus_if.rom_addr_i = 32'h40; #1;
    check("t6_miss", 32'(bus_if.stall_req_o), 32'd1);
    @(negedge clk); #1;
    check("t6_req", 32'(bus_if.mem_req_o), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("t6_rst_req", 32'(bus_if.mem_req_o), 32'd0);
    check("t6_rst_addr", bus_if.mem_addr_o, 32'd0);
    check("t6_rst_stall", 32'(bus_if.stall_req_o), 32'd0);
    check("t6_rst_data", bus_if.rom_data_o, 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    check("t6_post_miss", 32'(bus_if.stall_req_o), 32'd1);
    @(negedge clk);
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = 32'h6666_6666;
    sb.push_back('{32'h40, 32'h6666_6666});
    #1;
    check("t6_req_again", 32'(bus_if.mem_req_o), 32'd1);
    check("t6_addr_again", bus_if.mem_addr_o, 32'h40);
    @(negedge clk); bus_if.mem_ack_i = 1'b0; #1;
    expect_hit("t6_fill");

`ifdef ROM_BRIDGE_TIMEOUT_EN
    // No acknowledge: abort after four busy cycles with a NOP fill
    @(negedge clk); bus_if.rom_addr_i = 32'h80; #1;
    check("t7_miss", 32'(bus_if.stall_req_o), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check("t7_busy_req", 32'(bus_if.mem_req_o), 32'd1);
      check("t7_busy_err", 32'(bus_if.bus_err_o), 32'd0);
    end
    @(negedge clk); #1;
    check("t7_req_drop", 32'(bus_if.mem_req_o), 32'd0);
    check("t7_err_pulse", 32'(bus_if.bus_err_o), 32'd1);
    check("t7_stall", 32'(bus_if.stall_req_o), 32'd0);
    check("t7_nop", bus_if.rom_data_o, 32'd0);
    @(negedge clk); #1;
    check("t7_err_end", 32'(bus_if.bus_err_o), 32'd0);
`else
    // No timeout: a long wait keeps the request up and never errors
    @(negedge clk); bus_if.rom_addr_i = 32'h80; #1;
    check("t7_miss", 32'(bus_if.stall_req_o), 32'd1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      check("t7_wait_req", 32'(bus_if.mem_req_o), 32'd1);
      check("t7_wait_err", 32'(bus_if.bus_err_o), 32'd0);
    end
    @(negedge clk);
    bus_if.mem_ack_i = 1'b1; bus_if.mem_rdata_i = 32'h7777_7777;
    sb.push_back('{32'h80, 32'h7777_7777});
    #1;
    @(negedge clk); bus_if.mem_ack_i = 1'b0; #1;
    expect_hit("t7_late_fill");
    check("t7_err_none", 32'(bus_if.bus_err_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
